// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/bubble handling and multi-cycle accumulate carry.
// Optional EX_MEM_FLUSH_EN adds a flush input that clears every output, overriding stalls.
module ex_mem_reg #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned STALL_W = 6
) (
    input  logic                clk,
    input  logic                rst,
`ifdef EX_MEM_FLUSH_EN
    input  logic                flush,
`endif
    input  logic [STALL_W-1:0]  stall,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic                ex_whilo,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [1:0]          cnt_i,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_whilo,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [1:0]          cnt_o
);

    logic [ADDR_W-1:0]   wd_q, wd_d;
    logic                wreg_q, wreg_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                whilo_q, whilo_d;
    logic [2*DATA_W-1:0] hilo_q, hilo_d;
    logic [1:0]          cnt_q, cnt_d;

    logic ex_stall, mem_stall, clear;

    assign ex_stall  = stall[3];
    assign mem_stall = stall[4];

`ifdef EX_MEM_FLUSH_EN
    assign clear = flush;
`else
    assign clear = 1'b0;
`endif

    always_comb begin
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        whilo_d = whilo_q;
        hilo_d  = hilo_q;
        cnt_d   = cnt_q;
        if (clear) begin
            wd_d    = '0;
            wreg_d  = 1'b0;
            wdata_d = '0;
            hi_d    = '0;
            lo_d    = '0;
            whilo_d = 1'b0;
            hilo_d  = '0;
            cnt_d   = '0;
        end else if (!ex_stall) begin
            // Advance; the illegal EX-go/MEM-stall pattern also lands here.
            wd_d    = ex_wd;
            wreg_d  = ex_wreg;
            wdata_d = ex_wdata;
            hi_d    = ex_hi;
            lo_d    = ex_lo;
            whilo_d = ex_whilo;
            hilo_d  = '0;
            cnt_d   = '0;
        end else if (!mem_stall) begin
            // Bubble into MEM while the accumulate state loops back to EX.
            wd_d    = '0;
            wreg_d  = 1'b0;
            wdata_d = '0;
            hi_d    = '0;
            lo_d    = '0;
            whilo_d = 1'b0;
            hilo_d  = hilo_i;
            cnt_d   = cnt_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            wdata_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            whilo_q <= 1'b0;
            hilo_q  <= '0;
            cnt_q   <= '0;
        end else begin
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            whilo_q <= whilo_d;
            hilo_q  <= hilo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_wd    = wd_q;
    assign mem_wreg  = wreg_q;
    assign mem_wdata = wdata_q;
    assign mem_hi    = hi_q;
    assign mem_lo    = lo_q;
    assign mem_whilo = whilo_q;
    assign hilo_o    = hilo_q;
    assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized self-checking bench for ex_mem_reg against a behavioural stage model.
// Build with EX_MEM_FLUSH_EN defined to also exercise the flush port.
module tb_ex_mem_reg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned STALL_W = 6;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic [STALL_W-1:0]  stall;
    logic [ADDR_W-1:0]   ex_wd;
    logic                ex_wreg;
    logic [DATA_W-1:0]   ex_wdata, ex_hi, ex_lo;
    logic                ex_whilo;
    logic [2*DATA_W-1:0] hilo_i;
    logic [1:0]          cnt_i;
    logic [ADDR_W-1:0]   mem_wd;
    logic                mem_wreg;
    logic [DATA_W-1:0]   mem_wdata, mem_hi, mem_lo;
    logic                mem_whilo;
    logic [2*DATA_W-1:0] hilo_o;
    logic [1:0]          cnt_o;

    // Expected MEM-stage contents as a single record.
    typedef struct {
        logic [ADDR_W-1:0]   wd;
        logic                wreg;
        logic [DATA_W-1:0]   wdata, hi, lo;
        logic                whilo;
        logic [2*DATA_W-1:0] hilo;
        logic [1:0]          cnt;
    } stage_t;

    stage_t exp_s;
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ex_mem_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .STALL_W(STALL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef EX_MEM_FLUSH_EN
        .flush    (flush),
`endif
        .stall    (stall),
        .ex_wd    (ex_wd),
        .ex_wreg  (ex_wreg),
        .ex_wdata (ex_wdata),
        .ex_hi    (ex_hi),
        .ex_lo    (ex_lo),
        .ex_whilo (ex_whilo),
        .hilo_i   (hilo_i),
        .cnt_i    (cnt_i),
        .mem_wd   (mem_wd),
        .mem_wreg (mem_wreg),
        .mem_wdata(mem_wdata),
        .mem_hi   (mem_hi),
        .mem_lo   (mem_lo),
        .mem_whilo(mem_whilo),
        .hilo_o   (hilo_o),
        .cnt_o    (cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    endtask

    function automatic stage_t zero_stage();
        stage_t z;
        z.wd = '0; z.wreg = 1'b0; z.wdata = '0; z.hi = '0; z.lo = '0;
        z.whilo = 1'b0; z.hilo = '0; z.cnt = '0;
        return z;
    endfunction

    // Reference: what the stage holds after one clock given the current inputs.
    function automatic stage_t model_next(input stage_t cur);
        stage_t n;
        logic do_flush;
`ifdef EX_MEM_FLUSH_EN
        do_flush = flush;
`else
        do_flush = 1'b0;
`endif
        if (rst || do_flush) return zero_stage();
        case ({stall[4], stall[3]})
            2'b11: n = cur;
            2'b01: begin
                n = zero_stage();
                n.hilo = hilo_i;
                n.cnt  = cnt_i;
            end
            default: begin
                n.wd = ex_wd; n.wreg = ex_wreg; n.wdata = ex_wdata;
                n.hi = ex_hi; n.lo = ex_lo; n.whilo = ex_whilo;
                n.hilo = '0; n.cnt = '0;
            end
        endcase
        return n;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".mem_wd"},    64'(mem_wd),    64'(exp_s.wd));
        check({tag, ".mem_wreg"},  64'(mem_wreg),  64'(exp_s.wreg));
        check({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(exp_s.wdata));
        check({tag, ".mem_hi"},    64'(mem_hi),    64'(exp_s.hi));
        check({tag, ".mem_lo"},    64'(mem_lo),    64'(exp_s.lo));
        check({tag, ".mem_whilo"}, 64'(mem_whilo), 64'(exp_s.whilo));
        check({tag, ".hilo_o"},    hilo_o,         exp_s.hilo);
        check({tag, ".cnt_o"},     64'(cnt_o),     64'(exp_s.cnt));
    endtask

    // Inputs were driven away from the edge; clock once, advance the model, then compare.
    task automatic step(input string tag);
        check({tag, ".legal_stall"}, 64'(stall[4] & ~stall[3]), 64'd0);
        @(posedge clk);
        exp_s = model_next(exp_s);
        #1;
        check_all(tag);
    endtask

    task automatic rand_data();
        ex_wd    = ADDR_W'($urandom);
        ex_wreg  = 1'($urandom);
        ex_wdata = $urandom;
        ex_hi    = $urandom;
        ex_lo    = $urandom;
        ex_whilo = 1'($urandom);
        hilo_i   = {$urandom, $urandom};
        cnt_i    = 2'($urandom);
    endtask

    initial begin
        exp_s = zero_stage();
        flush = 1'b0;
        stall = '0;
        // 1. Reset with every input nonzero.
        rst = 1'b1;
        ex_wd = 5'h1f; ex_wreg = 1'b1; ex_wdata = 32'hffff_ffff; ex_hi = 32'h1;
        ex_lo = 32'h2; ex_whilo = 1'b1; hilo_i = 64'h5; cnt_i = 2'd3;
        #1;
        step("reset0");
        step("reset1");
        check("reset.hilo_zero", hilo_o, 64'd0);
        rst = 1'b0; stall = '0;
        ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h0000_1234;
        step("t1");
        check("t1.wd_lit", 64'(mem_wd), 64'd3);
        check("t1.wdata_lit", 64'(mem_wdata), 64'h1234);

        // 2. HI/LO pass-through.
        ex_whilo = 1'b1; ex_hi = 32'hDEAD_BEEF; ex_lo = 32'h0000_0001;
        step("t2");
        check("t2.hi_lit", 64'(mem_hi), 64'hDEAD_BEEF);
        check("t2.cnt_lit", 64'(cnt_o), 64'd0);

        // 3. Bubble carrying accumulate state, then advance.
        stall = 6'b001111; hilo_i = 64'h0000_0002_0000_0003; cnt_i = 2'b01; ex_wreg = 1'b1;
        step("t3a");
        check("t3a.hilo_lit", hilo_o, 64'h0000_0002_0000_0003);
        check("t3a.wreg_lit", 64'(mem_wreg), 64'd0);
        stall = '0; ex_wdata = 32'h5;
        step("t3b");
        check("t3b.wdata_lit", 64'(mem_wdata), 64'h5);

        // 4. Hold: load data, load accumulate, then freeze for 3 cycles.
        stall = '0; ex_wdata = 32'hAAAA_5555;
        step("t4load");
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step("t4hold_data");
        end
        check("t4.wdata_lit", 64'(mem_wdata), 64'hAAAA_5555);
        stall = 6'b001111; hilo_i = 64'h7; cnt_i = 2'd2;
        step("t4load_acc");
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step("t4hold_acc");
        end
        check("t4.hilo_lit", hilo_o, 64'h7);

        // 5. Reset in the middle of an accumulate sequence.
        stall = 6'b001000; hilo_i = 64'h1234_5678_9abc_def0; cnt_i = 2'd1;
        step("t5acc");
        rst = 1'b1;
        step("t5rst");
        check("t5.cnt_lit", 64'(cnt_o), 64'd0);
        rst = 1'b0;

`ifdef EX_MEM_FLUSH_EN
        // 6. Flush overrides a full hold.
        stall = '0; rand_data(); ex_wdata = 32'hCAFE_0001;
        step("t6load");
        stall = 6'b011111; flush = 1'b1;
        step("t6flush");
        check("t6.wdata_lit", 64'(mem_wdata), 64'd0);
        flush = 1'b0;
`endif

        // Randomized legal traffic.
        for (int i = 0; i < 600; i++) begin
            logic [1:0] sel;
            rand_data();
            sel = 2'($urandom_range(0, 2));
            stall = STALL_W'($urandom);
            case (sel)
                2'd0: begin stall[3] = 1'b0; stall[4] = 1'b0; end
                2'd1: begin stall[3] = 1'b1; stall[4] = 1'b0; end
                default: begin stall[3] = 1'b1; stall[4] = 1'b1; end
            endcase
            rst = ($urandom_range(0, 31) == 0);
`ifdef EX_MEM_FLUSH_EN
            flush = ($urandom_range(0, 15) == 0);
`endif
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
